// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin one-hot arbiter and its
// downstream one-hot select decoder.
package rr_onehot_arbiter_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Encodes a one-hot vector to its bit position; all-zero input gives 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of (req & ~mask),
// searching upward from ptr and wrapping 7->0.
module rr_pick8
  import rr_onehot_arbiter_pkg::*;
(
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     mask_i,
  output logic [N-1:0]     win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  logic [N-1:0]     eff;
  logic [IDX_W-1:0] cand;

  // Rotating priority scan; the index is derived from the one-hot so the
  // pair can never disagree.
  always_comb begin
    eff      = req_i & ~mask_i;
    win_oh_o = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr_i + IDX_W'(i);
      if (!any_o && eff[cand]) begin
        any_o          = 1'b1;
        win_oh_o[cand] = 1'b1;
      end
    end
    win_idx_o = onehot_to_idx(win_oh_o);
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered, sticky one-hot /
// index grant offered over a valid/ready handshake.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     reqData,
  input  logic             grantReady,
  input  logic             flush,
  output logic             grantValid,
  output logic [N-1:0]     grantOneHot,
  output logic [IDX_W-1:0] grantIndex,
  output logic [7:0]       grantCount
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     oh_q, oh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             accept;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick_mask;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  // On acceptance the picker already sees the advanced pointer and the
  // accepted bit masked off, giving back-to-back grants without a bubble.
  assign accept    = (state_q == OFFER) && grantReady && !flush;
  assign pick_ptr  = accept ? idx_q + IDX_W'(1) : ptr_q;
  assign pick_mask = accept ? oh_q : '0;

  rr_pick8 u_pick (
    .req_i    (reqData),
    .ptr_i    (pick_ptr),
    .mask_i   (pick_mask),
    .win_oh_o (pick_oh),
    .win_idx_o(pick_idx),
    .any_o    (pick_any)
  );

  // Next-state: flush aborts the offer, otherwise offer/accept/re-arbitrate.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    oh_d    = oh_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      oh_d    = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_d = OFFER;
            oh_d    = pick_oh;
            idx_d   = pick_idx;
          end
        end
        OFFER: begin
          if (grantReady) begin
            ptr_d = pick_ptr;
            cnt_d = cnt_q + 8'd1;
            if (pick_any) begin
              oh_d  = pick_oh;
              idx_d = pick_idx;
            end else begin
              state_d = IDLE;
              oh_d    = '0;
              idx_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      oh_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      oh_q    <= oh_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grantValid  = (state_q == OFFER);
  assign grantOneHot = oh_q;
  assign grantIndex  = idx_q;
  assign grantCount  = cnt_q;

endmodule
